// File: rtl/image_filter3x3.sv
// 3x3 neighbourhood filter for a raster grayscale stream: passthrough, Sobel, |Gx|, |Gy| or Gaussian,
// with an optional binary threshold. The output is the input cadence delayed by exactly one cycle.
module image_filter3x3 #(
    parameter int IMG_W        = 640,
    parameter int PIX_W        = 12,
    parameter int MAG_SHIFT    = 4,
    parameter int DEFAULT_MODE = 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSOF,
    input  logic             iDVAL,
    input  logic [PIX_W-1:0] iGRAY,
    input  logic [2:0]       iMODE,
    input  logic             iBIN_EN,
    input  logic [PIX_W-1:0] iTHRESH,
    output logic             oDVAL,
    output logic [PIX_W-1:0] oPIX,
    output logic             oWIN_VALID
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SW = PIX_W + 4;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);

    logic [XW-1:0]    x_q, x_d, x_cur, rd_addr;
    logic [1:0]       y_q, y_d, y_cur;
    logic [2:0]       mode_q, mode_d, eff_mode;
    logic             bin_en_q, bin_en_d;
    logic [PIX_W-1:0] thresh_q, thresh_d;

    logic [PIX_W-1:0] lb1_mem [0:IMG_W-1];
    logic [PIX_W-1:0] lb2_mem [0:IMG_W-1];
    logic [PIX_W-1:0] lb1_rd_q, lb2_rd_q;

    logic [PIX_W-1:0] col_new [0:2];
    logic [PIX_W-1:0] win_q   [0:8];
    logic [PIX_W-1:0] win_n   [0:8];
    logic [SW-1:0]    u       [0:8];

    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0]        abs_gx, abs_gy, mag, gsum;
    logic [PIX_W-1:0]     filt;
    logic                 win_valid;

    logic             dval_q;
    logic [PIX_W-1:0] pix_q;
    logic             winv_q;

    // The pixel arriving with iSOF already uses the newly presented configuration.
    always_comb begin
        mode_d   = mode_q;
        bin_en_d = bin_en_q;
        thresh_d = thresh_q;
        if (iSOF) begin
            mode_d   = iMODE;
            bin_en_d = iBIN_EN;
            thresh_d = iTHRESH;
        end
        eff_mode = (mode_d > 3'd4) ? 3'd1 : mode_d;
    end

    always_comb begin
        x_cur = iSOF ? '0 : x_q;
        y_cur = iSOF ? '0 : y_q;
        x_d   = x_cur;
        y_d   = y_cur;
        if (iDVAL) begin
            if (x_cur == X_LAST) begin
                x_d = '0;
                if (y_cur != 2'd3) begin
                    y_d = y_cur + 2'd1;
                end
            end else begin
                x_d = x_cur + 1'b1;
            end
        end
        // Prefetch the column the next pixel will need so the RAM read can be registered.
        rd_addr = iRST ? '0 : x_d;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_q      <= '0;
            y_q      <= '0;
            mode_q   <= 3'(DEFAULT_MODE);
            bin_en_q <= 1'b0;
            thresh_q <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            mode_q   <= mode_d;
            bin_en_q <= bin_en_d;
            thresh_q <= thresh_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iDVAL && !iRST) begin
            lb1_mem[x_cur] <= iGRAY;
            lb2_mem[x_cur] <= lb1_rd_q;
        end
        lb1_rd_q <= lb1_mem[rd_addr];
        lb2_rd_q <= lb2_mem[rd_addr];
    end

    assign col_new[0] = lb2_rd_q;
    assign col_new[1] = lb1_rd_q;
    assign col_new[2] = iGRAY;

    // Window index = row*3 + col; rows top/mid/bottom, columns left/centre/right.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            assign win_n[gi*3 + 0] = win_q[gi*3 + 1];
            assign win_n[gi*3 + 1] = win_q[gi*3 + 2];
            assign win_n[gi*3 + 2] = col_new[gi];
        end
        for (genvar gi = 0; gi < 9; gi++) begin : g_widen
            assign u[gi] = {{(SW-PIX_W){1'b0}}, win_n[gi]};
        end
    endgenerate

    always_ff @(posedge iCLK) begin
        if (iDVAL && !iRST) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_n[i];
            end
        end
    end

    function automatic logic [PIX_W-1:0] sat_shift(input logic [SW-1:0] v);
        logic [SW-1:0] s;
        s = v >> MAG_SHIFT;
        if (|s[SW-1:PIX_W]) begin
            return '1;
        end
        return s[PIX_W-1:0];
    endfunction

    always_comb begin
        gx     = $signed(u[2] + (u[5] << 1) + u[8]) - $signed(u[0] + (u[3] << 1) + u[6]);
        gy     = $signed(u[6] + (u[7] << 1) + u[8]) - $signed(u[0] + (u[1] << 1) + u[2]);
        abs_gx = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag    = abs_gx + abs_gy;
        gsum   = u[0] + (u[1] << 1) + u[2]
               + (u[3] << 1) + (u[4] << 2) + (u[5] << 1)
               + u[6] + (u[7] << 1) + u[8];
    end

    always_comb begin
        win_valid = (x_cur >= XW'(2)) && (y_cur >= 2'd2);
        case (eff_mode)
            3'd0:    filt = iGRAY;
            3'd2:    filt = sat_shift(abs_gx);
            3'd3:    filt = sat_shift(abs_gy);
            3'd4:    filt = gsum[SW-1:4];
            default: filt = sat_shift(mag);
        endcase
        if (eff_mode != 3'd0) begin
            if (bin_en_d) begin
                filt = (filt >= thresh_d) ? '1 : '0;
            end
            if (!win_valid) begin
                filt = '0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            dval_q <= 1'b0;
            pix_q  <= '0;
            winv_q <= 1'b0;
        end else begin
            dval_q <= iDVAL;
            if (iDVAL) begin
                pix_q  <= filt;
                winv_q <= win_valid;
            end
        end
    end

    assign oDVAL      = dval_q;
    assign oPIX       = pix_q;
    assign oWIN_VALID = winv_q;
endmodule

// File: tb/tb_image_filter3x3.sv
// Bench for image_filter3x3: frames of directed and random images checked against a
// convolution model computed directly over a stored copy of each frame.
module tb_image_filter3x3;
    localparam int IMG_W = 640;
    localparam int PIX_W = 12;
    localparam int MAXV  = 4095;
    localparam int BLANK = 20;
    localparam int MAXR  = 8;

    logic             iCLK = 1'b0;
    logic             iRST, iSOF, iDVAL, iBIN_EN;
    logic [PIX_W-1:0] iGRAY, iTHRESH;
    logic [2:0]       iMODE;
    logic             oDVAL, oWIN_VALID;
    logic [PIX_W-1:0] oPIX;

    always #5 iCLK = ~iCLK;

    image_filter3x3 #(.IMG_W(IMG_W), .PIX_W(PIX_W), .MAG_SHIFT(4), .DEFAULT_MODE(1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL), .iGRAY(iGRAY),
        .iMODE(iMODE), .iBIN_EN(iBIN_EN), .iTHRESH(iTHRESH),
        .oDVAL(oDVAL), .oPIX(oPIX), .oWIN_VALID(oWIN_VALID)
    );

    int checks = 0, passes = 0, fails = 0;
    int img [MAXR][IMG_W];
    int m_row, m_col, m_mode, m_bin, m_th;
    int exp_pix, exp_win, last_row, last_col;
    int n_in, n_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: convolve the stored frame around centre (x-1, r-1).
    task automatic model(input int r, input int x, output int pix, output int win);
        int md, gxv, gyv, v, gs;
        int wv [3] = '{1, 2, 1};
        int p [3][3];
        md  = (m_mode > 4) ? 1 : m_mode;
        win = (x >= 2 && r >= 2) ? 1 : 0;
        if (md == 0) begin
            pix = img[r][x];
            return;
        end
        if (win == 0) begin
            pix = 0;
            return;
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][x-2+j];
        gxv = 0; gyv = 0; gs = 0;
        for (int k = 0; k < 3; k++) begin
            gxv += wv[k] * (p[k][2] - p[k][0]);
            gyv += wv[k] * (p[2][k] - p[0][k]);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                gs += wv[i] * wv[j] * p[i][j];
        if (gxv < 0) gxv = -gxv;
        if (gyv < 0) gyv = -gyv;
        case (md)
            2:       v = gxv / 16;
            3:       v = gyv / 16;
            4:       v = gs / 16;
            default: v = (gxv + gyv) / 16;
        endcase
        if (v > MAXV) v = MAXV;
        if (m_bin != 0) v = (v >= m_th) ? MAXV : 0;
        pix = v;
    endtask

    task automatic step(input bit sof, input bit dv, input int gray,
                        input int mode_in, input int bin_in, input int th_in);
        iRST    = 1'b0;
        iSOF    = sof;
        iDVAL   = dv;
        iGRAY   = gray[PIX_W-1:0];
        iMODE   = mode_in[2:0];
        iBIN_EN = bin_in[0];
        iTHRESH = th_in[PIX_W-1:0];
        if (sof) begin
            m_row = 0; m_col = 0;
            m_mode = mode_in; m_bin = bin_in; m_th = th_in;
        end
        if (dv) begin
            img[m_row][m_col] = gray;
            model(m_row, m_col, exp_pix, exp_win);
            last_row = m_row; last_col = m_col;
            n_in++;
            m_col++;
            if (m_col == IMG_W) begin
                m_col = 0;
                if (m_row < MAXR - 1) m_row++;
            end
        end
        @(posedge iCLK);
        #1;
        chk("odval", {31'd0, oDVAL}, {31'd0, dv});
        if (oDVAL === 1'b1) n_out++;
        chk($sformatf("opix r%0d x%0d", last_row, last_col), {20'd0, oPIX}, exp_pix);
        chk($sformatf("owin r%0d x%0d", last_row, last_col), {31'd0, oWIN_VALID}, exp_win);
    endtask

    task automatic reset_cycles(input int n);
        iRST = 1'b1; iSOF = 1'b0; iDVAL = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK);
            #1;
            chk("rst odval", {31'd0, oDVAL}, 0);
            chk("rst opix", {20'd0, oPIX}, 0);
            chk("rst owin", {31'd0, oWIN_VALID}, 0);
        end
        iRST = 1'b0;
        m_row = 0; m_col = 0; m_mode = 1; m_bin = 0; m_th = 0;
        exp_pix = 0; exp_win = 0;
        $display("reset %0d cycles", n);
    endtask

    function automatic int gen(input int kind, input int r, input int x);
        case (kind)
            1:       return (x < 320) ? 0 : MAXV;
            2:       return (r >= 3) ? MAXV : 0;
            3:       return 2000;
            default: return int'($urandom_range(0, MAXV));
        endcase
    endfunction

    task automatic frame(input int rows, input int kind, input int mode, input int bin,
                         input int th, input int mode_mid, input bit gaps);
        int pv;
        for (int r = 0; r < rows; r++) begin
            for (int x = 0; x < IMG_W; x++) begin
                pv = gen(kind, r, x);
                step(r == 0 && x == 0, 1'b1, pv, (r == 0 && x == 0) ? mode : mode_mid, bin, th);
                if (kind == 1 && m_mode == 1 && m_bin == 0) begin
                    if (r >= 2 && (x == 320 || x == 321)) begin
                        chk("edge pix", {20'd0, oPIX}, 1023);
                        chk("edge win", {31'd0, oWIN_VALID}, 1);
                    end
                    if (r >= 2 && (x == 10 || x == 100 || x == 322 || x == 500))
                        chk("flat pix", {20'd0, oPIX}, 0);
                    if (r < 2) begin
                        chk("top win", {31'd0, oWIN_VALID}, 0);
                        chk("top pix", {20'd0, oPIX}, 0);
                    end
                end
                if (kind == 1 && m_mode == 1 && m_bin == 1 && m_th == 500)
                    chk("bin pix", {20'd0, oPIX}, (r >= 2 && (x == 320 || x == 321)) ? MAXV : 0);
                if (kind == 2 && m_mode == 3 && (r == 3 || r == 4) && x >= 2)
                    chk("gy pix", {20'd0, oPIX}, 1023);
                if (kind == 2 && m_mode == 2)
                    chk("gx pix", {20'd0, oPIX}, 0);
                if (kind == 3 && m_mode == 4 && r >= 2 && x >= 2)
                    chk("gauss pix", {20'd0, oPIX}, 2000);
                if (m_mode == 0)
                    chk("pass pix", {20'd0, oPIX}, pv);
                if (gaps && $urandom_range(0, 15) == 0)
                    step(1'b0, 1'b0, int'($urandom_range(0, MAXV)), mode_mid, bin, th);
            end
            for (int b = 0; b < BLANK; b++)
                step(1'b0, 1'b0, int'($urandom_range(0, MAXV)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)));
        end
        $display("frame kind=%0d mode=%0d bin=%0d th=%0d rows=%0d checks=%0d",
                 kind, mode, bin, th, rows, checks);
    endtask

    initial begin
        iRST = 1'b1; iSOF = 1'b0; iDVAL = 1'b0; iGRAY = '0;
        iMODE = 3'd0; iBIN_EN = 1'b0; iTHRESH = '0;
        n_in = 0; n_out = 0; last_row = 0; last_col = 0;

        // Reset and cadence on a random Sobel frame with scattered gaps
        reset_cycles(5);
        frame(3, 0, 1, 0, 0, 1, 1'b1);
        chk("count t1", n_out, n_in);

        // Vertical step edge, Sobel
        frame(6, 1, 1, 0, 0, 1, 1'b0);

        // Horizontal step: |Gy| then |Gx|
        frame(6, 2, 3, 0, 0, 3, 1'b0);
        frame(6, 2, 2, 0, 0, 2, 1'b0);

        // Gaussian on uniform image, passthrough and further random modes
        frame(4, 3, 4, 0, 0, 4, 1'b0);
        frame(3, 0, 0, 0, 0, 0, 1'b1);
        frame(3, 0, 2, 0, 0, 5, 1'b1);
        frame(3, 0, 4, 0, 0, 0, 1'b1);
        frame(3, 0, 6, 1, int'($urandom_range(0, 1023)), 3, 1'b1);
        frame(2, 0, 0, 1, 1000, 4, 1'b0);

        // Config only changes on iSOF; then binary threshold on the step edge
        frame(5, 1, 1, 0, 0, 0, 1'b0);
        frame(3, 1, 0, 0, 0, 1, 1'b0);
        frame(4, 1, 1, 1, 500, 1, 1'b0);

        // Reset at x=200 of row 3, then resume without iSOF
        for (int r = 0; r < 4; r++)
            for (int x = 0; x < ((r == 3) ? 200 : IMG_W); x++)
                step(r == 0 && x == 0, 1'b1, int'($urandom_range(0, MAXV)), 1, 0, 0);
        reset_cycles(3);
        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < IMG_W; x++) begin
                step(1'b0, 1'b1, int'($urandom_range(0, MAXV)), int'($urandom_range(0, 7)), 1, 0);
                if (r < 2) chk("post-rst win", {31'd0, oWIN_VALID}, 0);
                if (r == 2 && x >= 2) chk("post-rst win2", {31'd0, oWIN_VALID}, 1);
            end
            for (int b = 0; b < BLANK; b++)
                step(1'b0, 1'b0, 0, 0, 0, 0);
        end
        $display("post-reset rows done checks=%0d", checks);

        chk("count all", n_out, n_in);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
